// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch direction encoding and predictor configuration.
package mips_core_pkg;

  // Resolved or predicted branch direction.
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // Instructions are word aligned; PC bits below this offset carry no index information.
  localparam int unsigned PC_WORD_OFFSET = 2;

  // Meaning of the predictor's USE_GSHARE parameter.
  typedef enum logic {
    PRED_BIMODAL = 1'b0,
    PRED_GSHARE  = 1'b1
  } pred_mode_e;

endpackage

// File: rtl/sat_counter_update.sv
// Next-value computation for a saturating up/down counter.
// Ports:
//   ctr_i     current counter value
//   outcome_i TAKEN counts up, NOT_TAKEN counts down
//   ctr_o     next value, saturating at all-ones and zero (combinational)
module sat_counter_update
  import mips_core_pkg::*;
#(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  BranchOutcome        outcome_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (outcome_i == TAKEN) begin
      if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Dynamic branch direction predictor: gshare or bimodal table of saturating counters.
// Ports:
//   clk, rst_n                core clock, async active-low reset
//   i_req_valid, i_req_pc     fetch-side prediction request
//   o_req_prediction          predicted direction (combinational from state)
//   o_req_ghr                 history snapshot used for this prediction
//   i_fb_*                    resolved-branch feedback from execute
//   o_mispredict_count        saturating count of mispredicted feedbacks
module branch_predictor_gshare
  import mips_core_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned GHR_BITS   = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter bit          USE_GSHARE = 1'b1,
  parameter int unsigned CNT_BITS   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  input  logic [31:0]         i_req_pc,
  output BranchOutcome        o_req_prediction,
  output logic [GHR_BITS-1:0] o_req_ghr,
  input  logic                i_fb_valid,
  input  logic [31:0]         i_fb_pc,
  input  logic [GHR_BITS-1:0] i_fb_ghr,
  input  BranchOutcome        i_fb_prediction,
  input  BranchOutcome        i_fb_outcome,
  output logic [CNT_BITS-1:0] o_mispredict_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  // Weakly not-taken: one below the taken threshold.
  localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] table_q [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d, ghr_shift;
  logic [CNT_BITS-1:0] mispred_q, mispred_d;
  logic                active_q;
  logic                fb_en;
  logic [INDEX_BITS-1:0] req_idx, fb_idx;
  logic [CTR_BITS-1:0] fb_ctr, ctr_d;

  // Table index: word-aligned PC bits, optionally folded with history in the low bits.
  function automatic logic [INDEX_BITS-1:0] table_idx(input logic [INDEX_BITS-1:0] pc_bits,
                                                      input logic [GHR_BITS-1:0]   ghr);
    logic [INDEX_BITS-1:0] idx;
    idx = pc_bits;
    if (USE_GSHARE) idx = idx ^ INDEX_BITS'(ghr);
    return idx;
  endfunction

  assign req_idx = table_idx(i_req_pc[PC_WORD_OFFSET +: INDEX_BITS], ghr_q);
  assign fb_idx  = table_idx(i_fb_pc[PC_WORD_OFFSET +: INDEX_BITS], i_fb_ghr);
  assign fb_ctr  = table_q[fb_idx];

  // Request path reads registered state only, so a same-cycle feedback is not visible.
  assign o_req_prediction   = BranchOutcome'(table_q[req_idx][CTR_BITS-1]);
  assign o_req_ghr          = ghr_q;
  assign o_mispredict_count = mispred_q;

  // Valid only qualifies use of the prediction; PC bits outside the index do not matter.
  logic unused_inputs;
  assign unused_inputs = ^{i_req_valid,
                           i_req_pc[31:INDEX_BITS+PC_WORD_OFFSET], i_req_pc[PC_WORD_OFFSET-1:0],
                           i_fb_pc[31:INDEX_BITS+PC_WORD_OFFSET], i_fb_pc[PC_WORD_OFFSET-1:0],
                           i_fb_ghr};

  sat_counter_update #(
    .CTR_BITS (CTR_BITS)
  ) u_ctr_update (
    .ctr_i     (fb_ctr),
    .outcome_i (i_fb_outcome),
    .ctr_o     (ctr_d)
  );

  // Shift the resolved outcome into the live history (not the returned snapshot).
  generate
    if (GHR_BITS == 1) begin : g_ghr_single
      assign ghr_shift = GHR_BITS'(i_fb_outcome);
    end else begin : g_ghr_multi
      assign ghr_shift = {ghr_q[GHR_BITS-2:0], i_fb_outcome};
    end
  endgenerate

  // Feedback is dropped on the first edge after reset release.
  always_comb begin
    fb_en     = i_fb_valid & active_q;
    ghr_d     = ghr_q;
    mispred_d = mispred_q;
    if (fb_en) begin
      ghr_d = ghr_shift;
      if ((i_fb_prediction != i_fb_outcome) && (mispred_q != '1)) begin
        mispred_d = mispred_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q     <= '0;
      mispred_q <= '0;
      active_q  <= 1'b0;
    end else begin
      ghr_q     <= ghr_d;
      mispred_q <= mispred_d;
      active_q  <= 1'b1;
    end
  end

  // Counter table lives in flops so it can be reset to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= CTR_RESET;
    end else if (fb_en) begin
      table_q[fb_idx] <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a gshare instance (32-bit stats) and a bimodal
// instance (2-bit stats) share stimulus and are checked against a table model.
module tb_branch_predictor_gshare;
  import mips_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req_valid;
  logic [31:0]  req_pc;
  BranchOutcome pred_g, pred_b;
  logic [7:0]   ghr_g, ghr_b;
  logic         fb_valid;
  logic [31:0]  fb_pc;
  logic [7:0]   fb_ghr;
  BranchOutcome fb_pred, fb_out;
  logic [31:0]  cnt_g;
  logic [1:0]   cnt_b;

  branch_predictor_gshare #(
    .INDEX_BITS (8), .GHR_BITS (8), .CTR_BITS (2), .USE_GSHARE (1'b1), .CNT_BITS (32)
  ) dut_g (
    .clk (clk), .rst_n (rst_n), .i_req_valid (req_valid), .i_req_pc (req_pc),
    .o_req_prediction (pred_g), .o_req_ghr (ghr_g), .i_fb_valid (fb_valid),
    .i_fb_pc (fb_pc), .i_fb_ghr (fb_ghr), .i_fb_prediction (fb_pred),
    .i_fb_outcome (fb_out), .o_mispredict_count (cnt_g)
  );

  branch_predictor_gshare #(
    .INDEX_BITS (8), .GHR_BITS (8), .CTR_BITS (2), .USE_GSHARE (1'b0), .CNT_BITS (2)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .i_req_valid (req_valid), .i_req_pc (req_pc),
    .o_req_prediction (pred_b), .o_req_ghr (ghr_b), .i_fb_valid (fb_valid),
    .i_fb_pc (fb_pc), .i_fb_ghr (fb_ghr), .i_fb_prediction (fb_pred),
    .i_fb_outcome (fb_out), .o_mispredict_count (cnt_b)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: counters as integers 0..3, taken when >= 2; history as an integer.
  int     tbl_g [256];
  int     tbl_b [256];
  int     m_ghr;
  longint m_cnt_g;
  int     m_cnt_b;
  bit     m_live;
  int     ig, ib;

  function automatic int idx_of(input logic [31:0] pc, input int ghr, input bit gs);
    int i;
    i = int'((pc >> 2) & 32'hff);
    return gs ? (i ^ ghr) : i;
  endfunction

  function automatic int bump(input int c, input BranchOutcome o);
    if (o == TAKEN) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        tbl_g[i] = 1;
        tbl_b[i] = 1;
      end
      m_ghr   = 0;
      m_cnt_g = 0;
      m_cnt_b = 0;
      m_live  = 1'b0;
    end else begin
      if (m_live && fb_valid) begin
        ig = idx_of(fb_pc, int'(fb_ghr), 1'b1);
        ib = idx_of(fb_pc, int'(fb_ghr), 1'b0);
        tbl_g[ig] = bump(tbl_g[ig], fb_out);
        tbl_b[ib] = bump(tbl_b[ib], fb_out);
        m_ghr = ((m_ghr << 1) | ((fb_out == TAKEN) ? 1 : 0)) & 255;
        if (fb_pred != fb_out) begin
          if (m_cnt_g < 64'hFFFF_FFFF) m_cnt_g++;
          if (m_cnt_b < 3) m_cnt_b++;
        end
      end
      m_live = 1'b1;
    end
  end

  // Every cycle: outputs must match the model's pre-edge state.
  always @(negedge clk) begin
    if (started) begin
      check("pred_g", 64'(pred_g), (tbl_g[idx_of(req_pc, m_ghr, 1'b1)] >= 2) ? 64'd1 : 64'd0);
      check("pred_b", 64'(pred_b), (tbl_b[idx_of(req_pc, m_ghr, 1'b0)] >= 2) ? 64'd1 : 64'd0);
      check("ghr_g", 64'(ghr_g), 64'(m_ghr));
      check("ghr_b", 64'(ghr_b), 64'(m_ghr));
      check("cnt_g", 64'(cnt_g), 64'(m_cnt_g));
      check("cnt_b", 64'(cnt_b), 64'(m_cnt_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fb(input logic [31:0] pc, input logic [7:0] g, input BranchOutcome p,
                    input BranchOutcome o);
    fb_valid = 1'b1;
    fb_pc    = pc;
    fb_ghr   = g;
    fb_pred  = p;
    fb_out   = o;
    tick();
    fb_valid = 1'b0;
  endtask

  // Reset, release after an edge, and let the (ignored) release edge pass.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_pc    = 32'h0040_0010;
    fb_valid  = 1'b0;
    fb_pc     = '0;
    fb_ghr    = '0;
    fb_pred   = NOT_TAKEN;
    fb_out    = NOT_TAKEN;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;
    #1;
    check("rst_pred_g", 64'(pred_g), 64'(NOT_TAKEN));
    check("rst_pred_b", 64'(pred_b), 64'(NOT_TAKEN));
    check("rst_ghr", 64'(ghr_g), 64'h0);
    check("rst_cnt", 64'(cnt_g), 64'h0);
    tick();

    // Gshare: three TAKEN at PC 0x100 with snapshot 0.
    repeat (3) fb(32'h100, 8'h00, NOT_TAKEN, TAKEN);
    check("gs_ghr7", 64'(ghr_g), 64'h07);
    req_pc = 32'h100; #1;
    check("gs_idx47", 64'(pred_g), 64'(NOT_TAKEN));
    check("bi_idx40", 64'(pred_b), 64'(TAKEN));
    req_pc = 32'h11C; #1;
    check("gs_idx40_sat", 64'(pred_g), 64'(TAKEN));
    check("gs_cnt3", 64'(cnt_g), 64'd3);

    // Asynchronous mid-cycle reset.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pred", 64'(pred_g), 64'(NOT_TAKEN));
    check("arst_ghr", 64'(ghr_g), 64'h0);
    check("arst_cnt_g", 64'(cnt_g), 64'h0);
    check("arst_cnt_b", 64'(cnt_b), 64'h0);
    tick();
    rst_n = 1'b1;
    // Feedback during the release cycle must be ignored.
    fb(32'h14, 8'h00, NOT_TAKEN, TAKEN);
    check("rel_ghr", 64'(ghr_g), 64'h0);
    check("rel_cnt", 64'(cnt_g), 64'h0);

    // Same-cycle request and feedback on entry 0x05.
    fb_valid = 1'b1; fb_pc = 32'h14; fb_ghr = 8'h00; fb_pred = TAKEN; fb_out = TAKEN;
    req_pc = 32'h14; #1;
    check("rbw_g", 64'(pred_g), 64'(NOT_TAKEN));
    check("rbw_b", 64'(pred_b), 64'(NOT_TAKEN));
    tick();
    fb_valid = 1'b0; #1;
    check("after_b", 64'(pred_b), 64'(TAKEN));
    req_pc = 32'h10; #1;
    check("after_g", 64'(pred_g), 64'(TAKEN));

    // Bimodal saturation at PC 0x0040_0010.
    do_reset();
    req_pc = 32'h0040_0010;
    repeat (2) fb(32'h0040_0010, 8'h00, TAKEN, TAKEN);
    check("bi_taken", 64'(pred_b), 64'(TAKEN));
    repeat (3) fb(32'h0040_0010, 8'h00, NOT_TAKEN, NOT_TAKEN);
    check("bi_nt", 64'(pred_b), 64'(NOT_TAKEN));
    fb(32'h0040_0010, 8'h00, NOT_TAKEN, NOT_TAKEN);
    fb(32'h0040_0010, 8'h00, NOT_TAKEN, TAKEN);
    check("bi_floor", 64'(pred_b), 64'(NOT_TAKEN));

    // Mispredict counting and saturation.
    do_reset();
    fb(32'h20, 8'h00, TAKEN, TAKEN);
    fb(32'h24, 8'h00, TAKEN, NOT_TAKEN);
    fb(32'h28, 8'h00, NOT_TAKEN, NOT_TAKEN);
    fb(32'h2C, 8'h00, NOT_TAKEN, TAKEN);
    fb(32'h30, 8'h00, TAKEN, TAKEN);
    check("mp_g2", 64'(cnt_g), 64'd2);
    check("mp_b2", 64'(cnt_b), 64'd2);
    repeat (2) fb(32'h34, 8'h00, TAKEN, NOT_TAKEN);
    check("mp_g4", 64'(cnt_g), 64'd4);
    check("mp_b_sat", 64'(cnt_b), 64'd3);

    // Random traffic with occasional resets; the compare process does the checking.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      req_pc   = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      fb_valid = ($urandom_range(0, 3) != 0);
      fb_pc    = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      fb_ghr   = ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom);
      fb_out   = ($urandom_range(0, 3) != 0) ? TAKEN : NOT_TAKEN;
      fb_pred  = BranchOutcome'($urandom_range(0, 1));
      tick();
    end
    fb_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised dynamic branch direction predictor for the MIPS core, the successor to the static predictor built on the `BranchOutcome` enum. Fetch presents a PC and receives a `BranchOutcome` prediction plus a history snapshot in the same cycle. Execute returns the resolved outcome with that snapshot one or more cycles later; the predictor trains a table of saturating counters and advances its global history. The mode parameter selects gshare or plain bimodal indexing.

## Interface
- `INDEX_BITS`, 8: log2 of counter-table depth (256 entries).
- `GHR_BITS`, 8: global history length; must be 1..INDEX_BITS.
- `CTR_BITS`, 2: saturating counter width; must be ≥ 1.
- `USE_GSHARE`, 1: 1 = index is PC bits XOR history; 0 = bimodal, PC bits only.
- `CNT_BITS`, 32: width of mispredict statistic counter.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  1  fetch requests a prediction.
- `i_req_pc`  in  32  PC of the branch being fetched.
- `o_req_prediction`  out  BranchOutcome  predicted direction.
- `o_req_ghr`  out  GHR_BITS  history snapshot used for this prediction.
- `i_fb_valid`  in  1  resolved-branch feedback this cycle.
- `i_fb_pc`  in  32  PC of the resolved branch.
- `i_fb_ghr`  in  GHR_BITS  snapshot returned from `o_req_ghr`.
- `i_fb_prediction`  in  BranchOutcome  direction originally predicted.
- `i_fb_outcome`  in  BranchOutcome  actual direction.
- `o_mispredict_count`  out  CNT_BITS  saturating count of mispredicted feedbacks.

## Operation
- Index: `idx = pc[INDEX_BITS+1:2]`; when `USE_GSHARE`=1, XOR `ghr` into `idx[GHR_BITS-1:0]`; upper index bits pass unchanged.
- Request path is combinational from registered state: `o_req_prediction` = TAKEN iff counter MSB at `idx(i_req_pc, ghr)` is 1; `o_req_ghr` = current `ghr`. Outputs are driven regardless of `i_req_valid`; `i_req_valid` only qualifies use and has no state effect.
- Feedback (`i_fb_valid`=1), applied at the rising edge:
  - Counter at `idx(i_fb_pc, i_fb_ghr)`: increment if TAKEN, decrement if NOT_TAKEN, saturating at `2^CTR_BITS-1` and 0.
  - `ghr <= {ghr[GHR_BITS-2:0], i_fb_outcome}`; history is non-speculative, so no repair is needed. For GHR_BITS=1, `ghr <= i_fb_outcome`.
  - If `i_fb_prediction != i_fb_outcome`, `o_mispredict_count` increments, holding at all-ones.
- No state changes when `i_fb_valid`=0.

## Timing
- Reset (async assert, sync release on `clk`): every counter = `2^(CTR_BITS-1)-1` (weakly not-taken; 01 for 2-bit), `ghr` = 0, `o_mispredict_count` = 0. After reset, `o_req_prediction` = NOT_TAKEN for every PC and `o_req_ghr` = 0.
- Prediction latency is 0 cycles. A feedback update is visible to requests from the cycle after its edge.
- A request and a feedback in the same cycle, same entry: the prediction uses the pre-update counter and pre-update `ghr` (read-before-write).
- Back-to-back feedbacks to the same entry on consecutive cycles each apply; there is no lost update.
- Reset asserted mid-run clears all state immediately. A feedback in the reset-release cycle is ignored.
- Feedback with an `i_fb_ghr` that differs from the current `ghr` is legal. Training uses `i_fb_ghr`; history shifting uses the current `ghr`.

## Structure
- `BranchOutcome` comes from `mips_core_pkg`. Add to the package: `localparam` PC word-offset (2) and `typedef enum {PRED_BIMODAL, PRED_GSHARE}` for documentation of `USE_GSHARE`.
- One sub-module, `sat_counter_update` (combinational, parametrised on CTR_BITS): next-value computation from a counter and an outcome. Instantiate it once, on the feedback path.
- The table is a flop array of `2^INDEX_BITS × CTR_BITS`; it needs the reset, so no RAM macro is used.

## Test plan
- Reset, then request PC 0x0040_0010 → NOT_TAKEN, `o_req_ghr`=0, `o_mispredict_count`=0.
- Bimodal (`USE_GSHARE`=0): two TAKEN feedbacks for PC 0x0040_0010 → prediction TAKEN. Three NOT_TAKEN → counter 0, prediction NOT_TAKEN. A fourth NOT_TAKEN → counter stays 0.
- Gshare: feedback TAKEN ×3 at PC 0x100 with `i_fb_ghr`=0 → `ghr`=0x07. Request PC 0x100 now indexes 0x40^0x07=0x47 and predicts NOT_TAKEN. Entry 0x40 has saturated at 3.
- Same cycle: request and feedback both to entry 0x05, counter 1, feedback TAKEN → this cycle NOT_TAKEN, next cycle TAKEN.
- Mispredict count: 5 feedbacks, 2 with prediction≠outcome → count 2. With CNT_BITS=2, 4 mispredicts → holds at 3.
- Assert `rst_n` low mid-run after training → all outputs return to their reset values asynchronously, before the next clock edge.
